// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ==========================================================================
// pipe_ctrl_if : request inputs and pipeline-register controls of pipe_ctrl
// Revision     : 1.0
// ==========================================================================
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hz_stall;
  logic             br_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             imem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport master (
    output hz_stall, br_taken, dmem_req, dmem_ready, imem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_err, stall_cnt, state
  );

  modport slave (
    input  hz_stall, br_taken, dmem_req, dmem_ready, imem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_err, stall_cnt, state
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ==========================================================================
// pipe_ctrl : stall/flush sequencer for the 5-stage pipeline
// Revision  : 1.0
// ==========================================================================
module pipe_ctrl #(
  parameter int BR_FLUSH_CYC = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [3:0] C_FL_RELOAD = 4'(BR_FLUSH_CYC - 1);
  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam bit         C_USE_FLUSH = (BR_FLUSH_CYC > 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_wait_cnt, w_wait_nxt;
  logic [3:0]       r_fl_cnt, w_fl_nxt;
  logic             r_mem_err, w_mem_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_pc, w_ifw, w_ifl, w_idw, w_idb, w_exw;
  logic w_freeze, w_run_rules;

  assign w_freeze = bus.dmem_req & ~bus.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_fl_cnt    <= 4'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_fl_cnt   <= w_fl_nxt;
      r_mem_err  <= w_mem_err_nxt;
      if (!w_pc && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_fl_nxt      = r_fl_cnt;
    w_mem_err_nxt = r_mem_err;
    w_pc          = 1'b1;
    w_ifw         = 1'b1;
    w_ifl         = 1'b0;
    w_idw         = 1'b1;
    w_idb         = 1'b0;
    w_exw         = 1'b1;
    w_run_rules   = 1'b0;

    case (r_state)
      RUN: begin
        if (w_freeze) begin
          {w_pc, w_ifw, w_idw, w_exw} = 4'b0000;
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = 8'd1;
        end else begin
          w_run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          {w_pc, w_ifw, w_idw, w_exw} = 4'b0000;
          if (r_wait_cnt == C_WAIT_LAST) begin
            w_state_nxt   = ERR;
            w_mem_err_nxt = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end else begin
          // Release cycle: whatever was held in EX resolves now
          w_state_nxt = RUN;
          w_run_rules = 1'b1;
        end
      end
      FLUSH: begin
        if (w_freeze) begin
          {w_pc, w_ifw, w_idw, w_exw} = 4'b0000;
        end else if (bus.br_taken) begin
          w_ifl    = 1'b1;
          w_idb    = 1'b1;
          w_fl_nxt = C_FL_RELOAD;
        end else begin
          w_ifl = 1'b1;
          w_pc  = bus.imem_ready;
          if (r_fl_cnt == 4'd1) w_state_nxt = RUN;
          else                  w_fl_nxt    = r_fl_cnt - 4'd1;
        end
      end
      default: begin
        {w_pc, w_ifw, w_idw, w_exw} = 4'b0000;
      end
    endcase

    if (w_run_rules) begin
      if (bus.br_taken) begin
        w_ifl = 1'b1;
        w_idb = 1'b1;
        if (C_USE_FLUSH) begin
          w_state_nxt = FLUSH;
          w_fl_nxt    = C_FL_RELOAD;
        end
      end else if (bus.hz_stall) begin
        w_pc  = 1'b0;
        w_ifw = 1'b0;
        w_idb = 1'b1;
      end else if (!bus.imem_ready) begin
        w_pc  = 1'b0;
        w_ifl = 1'b1;
      end
    end
  end

  assign bus.pc_write     = rst_n & w_pc;
  assign bus.if_id_write  = rst_n & w_ifw;
  assign bus.if_id_flush  = rst_n & w_ifl;
  assign bus.id_ex_write  = rst_n & w_idw;
  assign bus.id_ex_bubble = rst_n & w_idb;
  assign bus.ex_mem_write = rst_n & w_exw;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.state        = r_state;

endmodule
`default_nettype wire
